multibyte_add_ctrl: RTL and testbench
=====================================

Name: multibyte_add_ctrl

Overview:
Byte-serial wide add/subtract sequencer built on one shared eight_bit_adder instance. It latches two NBYTES-wide operands, feeds one byte per cycle through the 8-bit adder LSB-first, and chains the carry through a register. It raises a one-cycle done pulse and holds the result until the next accepted start. It is the control layer that turns the 8-bit ripple adder into an N×8-bit arithmetic unit.

Parameters:
NBYTES, 4, operand width in bytes (legal range 2..16); W = 8*NBYTES.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
sub  input  1  sampled with start; 0 = a+b, 1 = a-b
a  input  W  operand A, sampled on accepted start
b  input  W  operand B, sampled on accepted start
ready  output  1  high in IDLE and DONE (new start accepted)
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result is valid
sum  output  W  result; held stable from done until next accepted start
cout  output  1  final carry out (for sub: 1 = no borrow, a>=b unsigned)
ovf  output  1  signed two's-complement overflow of the W-bit operation

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; sum=0, cout=0, ovf=0, done=0, busy=0; byte index=0; carry reg=0; operand regs=0. Reset wins over every other input, including in RUN (the operation is aborted and no done pulse follows).
- Datapath: exactly one eight_bit_adder instance. Inputs: a_reg byte[idx], b_eff byte[idx], carry reg. Its sum byte and carry out are registered each RUN cycle.
- Accept: when start=1 and ready=1, latch a_reg=a and b_eff = sub ? ~b : b. Set carry reg = sub, idx=0, clear done. Enter RUN. sum/cout/ovf keep their old values until overwritten.
- start while busy=1: ignored, with no effect on state or operands.
- RUN, each cycle: sum[8*idx+7:8*idx] <= adder sum byte; carry reg <= adder carry out; idx <= idx+1. When idx==NBYTES-1:
  - cout <= adder carry out
  - ovf <= (a_reg[W-1]==b_eff[W-1]) && (adder sum bit7 != a_reg[W-1])
  - go to DONE.
- DONE: done=1 for exactly this cycle. ready=1. With no start, the next state is IDLE and done=0. A start in DONE is accepted (back-to-back): the next state is RUN, and done stays 1 only for the DONE cycle itself.
- IDLE: ready=1, busy=0, done=0. Outputs hold the last result.
- Latency: start accepted at edge k, result bytes written at edges k+1..k+NBYTES, done=1 in the cycle after edge k+NBYTES.
  - Throughput is one operation per NBYTES+1 cycles with back-to-back starts.
- Width rules: idx is ceil(log2(NBYTES)) bits and never exceeds NBYTES-1. The carry is never dropped between bytes. No saturation: the result wraps modulo 2^W.
- Operand inputs a, b, sub are don't-care outside the accepting cycle.

Test Plan:
- NBYTES=4, add 0x000000FF + 0x00000001 -> done exactly 5 cycles after start; sum=0x00000100, cout=0, ovf=0.
- Add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0. Then add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- sub=1: 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Start 0x11111111+0x22222222, then pulse start with 0xFFFFFFFF+0xFFFFFFFF two cycles later (busy) -> second request ignored; sum=0x33333333, a single done pulse, ready=1 afterwards.
- Back-to-back: assert start again in the DONE cycle with 0x00000001+0x00000001 -> first done pulse seen; busy next cycle; second done 5 cycles later with sum=0x00000002. Both done pulses are exactly 1 cycle wide.
- Drop rst_n for one cycle during RUN (idx=2) -> next cycle: IDLE, ready=1, busy=0, sum=0, cout=0, ovf=0; no done pulse for the aborted operation.

Source files
------------

// File: rtl/multibyte_add_ctrl.sv
// Byte-serial W-bit add/subtract sequencer: one shared 8-bit adder, LSB byte first,
// carry chained through a register between cycles.
module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module multibyte_add_ctrl #(
  parameter int NBYTES = 4,
  localparam int W     = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, nxt;
  logic [W-1:0]   a_reg, b_eff, sum_q;
  logic [IW-1:0]  idx;
  logic           cy, cout_q, ovf_q;
  logic [7:0]     add_s;
  logic           add_c;
  logic           accept, last;
  logic [IW+2:0]  boff;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(NBYTES - 1));
  assign boff   = {idx, 3'b000};

  eight_bit_adder u_add (
    .a   (a_reg[boff +: 8]),
    .b   (b_eff[boff +: 8]),
    .cin (cy),
    .s   (add_s),
    .cout(add_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // Subtract is a + ~b + 1: invert B once at accept and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_eff  <= '0;
      sum_q  <= '0;
      idx    <= '0;
      cy     <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_eff <= sub ? ~b : b;
      cy    <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[boff +: 8] <= add_s;
      cy               <= add_c;
      if (last) begin
        idx    <= '0;
        cout_q <= add_c;
        ovf_q  <= (a_reg[W-1] == b_eff[W-1]) && (add_s[7] != a_reg[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench for multibyte_add_ctrl at NBYTES=4; inputs driven and outputs sampled on negedge.
module tb_multibyte_add_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] a, b, sum;
  logic         ready, busy, done, cout, ovf;

  int total = 0;
  int bad   = 0;

  multibyte_add_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns number of negedges until done (capped at 20).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] esum, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    start = 1'b1; a = x; b = y; sub = s;
    @(negedge clk);
    start = 1'b0; a = '1; b = '1; sub = ~s;
    chk({tag, ".busy"}, busy, 1'b1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, 5);
    chk({tag, ".sum"}, sum, esum);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, ".done_w"}, done, 1'b0);
    chk({tag, ".ready"}, ready, 1'b1);
  endtask

  initial begin
    int n, pulses;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", ready, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 1'b0);
    rst_n = 1'b1;

    run_op("add_ff_1",  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("add_carry", 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; a = 32'h11111111; b = 32'h22222222; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    chk("ign.busy", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("ign.pulses", pulses, 1);
    chk("ign.sum", sum, 32'h33333333);
    chk("ign.cout", cout, 1'b0);
    chk("ign.ready", ready, 1'b1);

    // Back-to-back: restart in the DONE cycle.
    @(negedge clk);
    start = 1'b1; a = 32'h12345678; b = 32'h11111111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("b2b.lat1", n, 4);
    chk("b2b.sum1", sum, 32'h23456789);
    start = 1'b1; a = 32'h00000001; b = 32'h00000001; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.done_w", done, 1'b0);
    chk("b2b.busy", busy, 1'b1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.lat2", n, 5);
    chk("b2b.sum2", sum, 32'h00000002);
    @(negedge clk);
    chk("b2b.done_w2", done, 1'b0);

    // Reset mid-RUN at idx=2 aborts with no done.
    @(negedge clk);
    start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.ready", ready, 1'b1);
    chk("abort.busy", busy, 1'b0);
    chk("abort.sum", sum, 0);
    chk("abort.cout", cout, 1'b0);
    chk("abort.ovf", ovf, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort.nodone", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
